// File: rtl/activation_sram_stream.sv
// Multi-channel activation SRAM: SFU write-back port plus NUM_CH strided 2-D
// read streamers, each with its own FSM and registered valid/ready output.

module activation_sram_stream_ch #(
   parameter int AW        = 15,
   parameter int MEM_WIDTH = 8,
   parameter int LANES     = 8,
   parameter int ADDR_W    = 32,
   parameter int LEN_W     = 16,
   parameter int WID_W     = 6,
   parameter int JUMP_W    = 16
) (
   input  logic                       clk,
   input  logic                       RST,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [ADDR_W-1:0]          cmd_addr,
   input  logic [LEN_W-1:0]           cmd_length,
   input  logic [WID_W-1:0]           cmd_width,
   input  logic [JUMP_W-1:0]          cmd_jump,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*MEM_WIDTH-1:0] out_data,
   output logic                       out_row_last,
   output logic                       out_last,
   output logic                       done,
   output logic [AW-1:0]              rd_addr,
   input  logic [LANES*MEM_WIDTH-1:0] rd_data
);
   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} st_t;

   st_t                       st;
   logic [LEN_W-1:0]          len_r, col;
   logic [WID_W-1:0]          wid_r, row;
   logic [AW-1:0]             jump_r, base;
   logic                      issue, row_end, last_row;
   logic [LANES*MEM_WIDTH-1:0] beat;

   assign cmd_ready = (st == IDLE);
   assign rd_addr   = base + AW'(col);
   assign issue     = (st == STREAM) && (!out_valid || out_ready);
   assign row_end   = ({1'b0, col} + (LEN_W+1)'(LANES)) >= {1'b0, len_r};
   assign last_row  = ({1'b0, row} + 1'b1) == {1'b0, wid_r};

   // lanes past the row end are forced to zero so rows never share a beat
   always_comb begin
      beat = '0;
      for (int k = 0; k < LANES; k++)
         if (({1'b0, col} + (LEN_W+1)'(k)) < {1'b0, len_r})
            beat[k*MEM_WIDTH +: MEM_WIDTH] = rd_data[k*MEM_WIDTH +: MEM_WIDTH];
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         st           <= IDLE;
         len_r        <= '0;
         wid_r        <= '0;
         jump_r       <= '0;
         base         <= '0;
         col          <= '0;
         row          <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_row_last <= 1'b0;
         out_last     <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (st)
            IDLE: if (cmd_valid) begin
               len_r  <= cmd_length;
               wid_r  <= cmd_width;
               jump_r <= AW'(cmd_jump);
               base   <= AW'(cmd_addr);
               col    <= '0;
               row    <= '0;
               st     <= (cmd_length == '0 || cmd_width == '0) ? FLUSH : STREAM;
            end
            STREAM: if (issue) begin
               out_valid    <= 1'b1;
               out_data     <= beat;
               out_row_last <= row_end;
               out_last     <= row_end && last_row;
               if (row_end) begin
                  col  <= '0;
                  row  <= row + 1'b1;
                  base <= base + jump_r;
                  if (last_row) st <= FLUSH;
               end else begin
                  col <= col + LEN_W'(LANES);
               end
            end
            FLUSH: begin
               // done pulses once the last beat is gone; IDLE follows the pulse
               if (done)            st   <= IDLE;
               else if (!out_valid) done <= 1'b1;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

module activation_sram_stream #(
   parameter int    MEM_DEPTH = 32768,
   parameter int    MEM_WIDTH = 8,
   parameter int    NUM_CH    = 4,
   parameter int    LANES     = 8,
   parameter int    ADDR_W    = 32,
   parameter int    LEN_W     = 16,
   parameter int    WID_W     = 6,
   parameter int    JUMP_W    = 16,
   parameter string INIT_FILE = ""
) (
   input  logic                              clk,
   input  logic                              RST,
   input  logic [NUM_CH-1:0]                 cmd_valid,
   output logic [NUM_CH-1:0]                 cmd_ready,
   input  logic [NUM_CH*ADDR_W-1:0]          cmd_addr,
   input  logic [NUM_CH*LEN_W-1:0]           cmd_length,
   input  logic [NUM_CH*WID_W-1:0]           cmd_width,
   input  logic [NUM_CH*JUMP_W-1:0]          cmd_jump,
   output logic [NUM_CH-1:0]                 out_valid,
   input  logic [NUM_CH-1:0]                 out_ready,
   output logic [NUM_CH*LANES*MEM_WIDTH-1:0] out_data,
   output logic [NUM_CH-1:0]                 out_row_last,
   output logic [NUM_CH-1:0]                 out_last,
   output logic [NUM_CH-1:0]                 done,
   input  logic                              wr_en,
   input  logic [ADDR_W-1:0]                 wr_addr,
   input  logic [LANES*MEM_WIDTH-1:0]        wr_data,
   input  logic [LANES-1:0]                  wr_mask
);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam int BW = LANES*MEM_WIDTH;

   logic [MEM_WIDTH-1:0]          mem [MEM_DEPTH];
   logic [NUM_CH-1:0][AW-1:0]     rd_addr;
   logic [NUM_CH-1:0][BW-1:0]     rd_data;
   logic [AW-1:0]                 wr_base;

   initial begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
   end

   assign wr_base = AW'(wr_addr);

   // address arithmetic at AW bits gives the modulo-depth wrap for free
   always_ff @(posedge clk) begin
      if (wr_en)
         for (int k = 0; k < LANES; k++)
            if (wr_mask[k]) mem[wr_base + AW'(k)] <= wr_data[k*MEM_WIDTH +: MEM_WIDTH];
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         assign rd_data[c][k*MEM_WIDTH +: MEM_WIDTH] = mem[rd_addr[c] + AW'(k)];
      end

      activation_sram_stream_ch #(
         .AW(AW), .MEM_WIDTH(MEM_WIDTH), .LANES(LANES), .ADDR_W(ADDR_W),
         .LEN_W(LEN_W), .WID_W(WID_W), .JUMP_W(JUMP_W)
      ) u_ch (
         .clk          (clk),
         .RST          (RST),
         .cmd_valid    (cmd_valid[c]),
         .cmd_ready    (cmd_ready[c]),
         .cmd_addr     (cmd_addr[c*ADDR_W +: ADDR_W]),
         .cmd_length   (cmd_length[c*LEN_W +: LEN_W]),
         .cmd_width    (cmd_width[c*WID_W +: WID_W]),
         .cmd_jump     (cmd_jump[c*JUMP_W +: JUMP_W]),
         .out_valid    (out_valid[c]),
         .out_ready    (out_ready[c]),
         .out_data     (out_data[c*BW +: BW]),
         .out_row_last (out_row_last[c]),
         .out_last     (out_last[c]),
         .done         (done[c]),
         .rd_addr      (rd_addr[c]),
         .rd_data      (rd_data[c])
      );
   end
endmodule
